// File: rtl/pe_chain_seq.sv
// rtl/pe_chain_seq.sv - command sequencer feeding a chain of GF processing elements
module pe_chain_seq #(
    parameter int GF_BIT      = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int N_PE        = 16,
    parameter int LEN_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [GF_BIT-1:0]      src_dataA,
    input  logic [GF_BIT-1:0]      src_dataB,
    output logic                   pe_start,
    output logic [OP_CODE_LEN-1:0] pe_op,
    output logic [1:0]             pe_gauss_op,
    output logic [GF_BIT-1:0]      pe_data,
    output logic [GF_BIT-1:0]      pe_dataB,
    output logic                   pe_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    localparam int DRAIN_W = $clog2(N_PE + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [1:0]               r_op;
    logic [LEN_W-1:0]         r_len;
    logic                     r_err_lat;
    // one extra bit so a full-scale length never wraps the beat count
    logic [LEN_W:0]           r_beat;
    logic [DRAIN_W-1:0]       r_drain;

    logic                     r_pe_start;
    logic [OP_CODE_LEN-1:0]   r_pe_op;
    logic [1:0]               r_pe_gauss;
    logic [GF_BIT-1:0]        r_pe_data;
    logic [GF_BIT-1:0]        r_pe_dataB;
    logic                     r_pe_valid;
    logic                     r_done;
    logic                     r_err;

    logic                     w_cmd_acc;
    logic                     w_src_acc;
    logic                     w_last_beat;
    logic                     w_drain_end;
    logic [OP_CODE_LEN-1:0]   w_mode_op;
    logic [1:0]               w_mode_gauss;

    assign w_cmd_acc   = cmd_valid && cmd_ready;
    assign w_src_acc   = src_valid && src_ready;
    assign w_last_beat = ((r_beat + (LEN_W+1)'(1)) == {1'b0, r_len});
    assign w_drain_end = (r_drain == DRAIN_W'(N_PE - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd_acc) w_next = (cmd_op == 2'd3) ? S_DONE : S_LOAD;
            S_LOAD:   if (w_src_acc) w_next = (r_len != '0) ? S_STREAM : S_DRAIN;
            S_STREAM: if (w_src_acc && w_last_beat) w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_end) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // handshake decodes from the state register and opcode-to-mode mapping
    always_comb begin
        cmd_ready    = (r_state == S_IDLE);
        src_ready    = (r_state == S_LOAD) || (r_state == S_STREAM);
        busy         = (r_state != S_IDLE);
        w_mode_op    = '0;
        w_mode_gauss = 2'b00;
        case (r_op)
            2'd0: begin w_mode_op = OP_CODE_LEN'(4'b1000); w_mode_gauss = 2'b00; end
            2'd1: begin w_mode_op = OP_CODE_LEN'(4'b1010); w_mode_gauss = 2'b11; end
            2'd2: begin w_mode_op = OP_CODE_LEN'(4'b1110); w_mode_gauss = 2'b10; end
            default: begin w_mode_op = '0; w_mode_gauss = 2'b00; end
        endcase
    end

    // command latch, counters and registered PE/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_len      <= '0;
            r_err_lat  <= 1'b0;
            r_beat     <= '0;
            r_drain    <= '0;
            r_pe_start <= 1'b0;
            r_pe_op    <= '0;
            r_pe_gauss <= 2'b00;
            r_pe_data  <= '0;
            r_pe_dataB <= '0;
            r_pe_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_op      <= cmd_op;
                r_len     <= cmd_len;
                r_err_lat <= (cmd_op == 2'd3);
            end
            if (w_cmd_acc)
                r_beat <= '0;
            else if ((r_state == S_STREAM) && w_src_acc)
                r_beat <= r_beat + (LEN_W+1)'(1);
            r_drain    <= (r_state == S_DRAIN) ? r_drain + DRAIN_W'(1) : '0;
            // a cycle without an accepted beat is a bubble; only pe_op keeps its value
            r_pe_valid <= w_src_acc;
            r_pe_start <= w_src_acc && (r_state == S_LOAD);
            r_pe_gauss <= w_src_acc ? w_mode_gauss : 2'b00;
            r_pe_data  <= w_src_acc ? src_dataA : '0;
            r_pe_dataB <= w_src_acc ? src_dataB : '0;
            if (w_src_acc) r_pe_op <= w_mode_op;
            r_done     <= (r_state == S_DONE);
            r_err      <= (r_state == S_DONE) && r_err_lat;
        end
    end

    assign pe_start    = r_pe_start;
    assign pe_op       = r_pe_op;
    assign pe_gauss_op = r_pe_gauss;
    assign pe_data     = r_pe_data;
    assign pe_dataB    = r_pe_dataB;
    assign pe_valid    = r_pe_valid;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_pe_chain_seq.sv
// tb/tb_pe_chain_seq.sv - directed self-checking bench for pe_chain_seq
module tb_pe_chain_seq;

    localparam int MAXC = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       src_valid;
    logic       src_ready;
    logic [3:0] src_dataA;
    logic [3:0] src_dataB;
    logic       pe_start;
    logic [3:0] pe_op;
    logic [1:0] pe_gauss_op;
    logic [3:0] pe_data;
    logic [3:0] pe_dataB;
    logic       pe_valid;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct packed {
        logic       cr;
        logic       sr;
        logic       bz;
        logic       dn;
        logic       er;
        logic       v;
        logic       st;
        logic [3:0] op;
        logic [1:0] g;
        logic [3:0] a;
        logic [3:0] b;
    } obs_t;

    obs_t obs [0:MAXC];
    int   done_cycle;
    int   last_c;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pe_chain_seq #(.GF_BIT(4), .OP_CODE_LEN(4), .N_PE(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_dataA(src_dataA), .src_dataB(src_dataB),
        .pe_start(pe_start), .pe_op(pe_op), .pe_gauss_op(pe_gauss_op), .pe_data(pe_data),
        .pe_dataB(pe_dataB), .pe_valid(pe_valid), .busy(busy), .done(done), .err(err)
    );

    function automatic obs_t sample();
        obs_t o;
        o.cr = cmd_ready; o.sr = src_ready; o.bz = busy; o.dn = done; o.er = err;
        o.v = pe_valid; o.st = pe_start; o.op = pe_op; o.g = pe_gauss_op;
        o.a = pe_data; o.b = pe_dataB;
        return o;
    endfunction

    // Offer one command, then stream beat k as A=(2k+1), B=(2k+2) mod 16.
    // Cycle c is sampled at the c-th falling edge after the command edge.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] len, input bit alt,
                           input bit hold_cmd, input int rst_at, input int ncyc);
        int bk;
        bit vn;
        bk = 0;
        done_cycle = -1;
        for (int i = 0; i <= MAXC; i++) obs[i] = '0;
        @(negedge clk);
        obs[0] = sample();
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; src_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            obs[c] = sample();
            last_c = c;
            if (done && done_cycle < 0) done_cycle = c;
            if (hold_cmd && done_cycle < 0) begin
                cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 8'd7;
            end else begin
                cmd_valid = 1'b0;
            end
            rst = (c == rst_at);
            vn = alt ? ((c % 2) == 0) : 1'b1;
            src_valid = vn;
            src_dataA = 4'((2 * bk + 1) & 15);
            src_dataB = 4'((2 * bk + 2) & 15);
            if (vn && src_ready) bk++;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        src_valid = 1'b0; cmd_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
        src_valid = 1'b0; src_dataA = '0; src_dataB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e = '0; e.cr = 1'b1;
        n_tests++;
        if (sample() !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", sample(), e);
        end
    endtask

    task automatic test_mul_mat();
        obs_t e;
        int nv, nb, nbz;
        run_cmd(2'd0, 8'd3, 1'b0, 1'b0, -1, 40);
        n_tests++;
        if (done_cycle !== 22) begin
            n_fail++; $display("FAIL mul_done_cycle: got %0d expected 22", done_cycle);
        end
        for (int k = 0; k < 4; k++) begin
            e = obs[2 + k];
            e.v = 1'b1; e.st = (k == 0); e.op = 4'b1000; e.g = 2'b00;
            e.a = 4'(2 * k + 1); e.b = 4'(2 * k + 2);
            n_tests++;
            if (obs[2 + k] !== e) begin
                n_fail++; $display("FAIL mul_beat%0d: got %h expected %h", k, obs[2 + k], e);
            end
        end
        nb = 0; nv = 0; nbz = 0;
        for (int c = 6; c <= 21; c++)
            if (!obs[c].v && !obs[c].st && obs[c].g == 2'b00 && obs[c].a == 0 && obs[c].b == 0 && obs[c].op == 4'b1000) nb++;
        for (int c = 1; c <= 22; c++) begin
            if (obs[c].v) nv++;
            if (obs[c].bz && !obs[c].cr) nbz++;
        end
        n_tests++;
        if (nb !== 16) begin n_fail++; $display("FAIL mul_drain_bubbles: got %0d expected 16", nb); end
        n_tests++;
        if (nv !== 4) begin n_fail++; $display("FAIL mul_valid_count: got %0d expected 4", nv); end
        n_tests++;
        if (nbz !== 21) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 21", nbz); end
        n_tests++;
        if (obs[22].er !== 1'b0) begin n_fail++; $display("FAIL mul_err: got %b expected 0", obs[22].er); end
    endtask

    task automatic test_eval_bubbles();
        int nv, bad, k;
        run_cmd(2'd1, 8'd2, 1'b1, 1'b0, -1, 60);
        n_tests++;
        if (done_cycle !== 24) begin
            n_fail++; $display("FAIL eval_done_cycle: got %0d expected 24", done_cycle);
        end
        nv = 0; bad = 0;
        for (int c = 2; c < 24; c++) begin
            if (obs[c].v) begin
                k = nv;
                if (c != 3 + 2 * k || obs[c].g != 2'b11 || obs[c].op != 4'b1010 ||
                    obs[c].a != 4'(2 * k + 1) || obs[c].b != 4'(2 * k + 2) || obs[c].st != (k == 0))
                    bad++;
                nv++;
            end else if (obs[c].st || obs[c].g != 2'b00 || obs[c].a != 0 || obs[c].b != 0) begin
                bad++;
            end
        end
        n_tests++;
        if (nv !== 3) begin n_fail++; $display("FAIL eval_valid_count: got %0d expected 3", nv); end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL eval_beat_pattern: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_gauss_len0();
        obs_t e;
        int nbz, ncr;
        run_cmd(2'd2, 8'd0, 1'b0, 1'b1, -1, 40);
        e = obs[2];
        e.v = 1'b1; e.st = 1'b1; e.op = 4'b1110; e.g = 2'b10; e.a = 4'd1; e.b = 4'd2;
        n_tests++;
        if (obs[2] !== e) begin n_fail++; $display("FAIL gauss_load: got %h expected %h", obs[2], e); end
        n_tests++;
        if (done_cycle !== 19) begin n_fail++; $display("FAIL gauss_done_cycle: got %0d expected 19", done_cycle); end
        nbz = 0; ncr = 0;
        for (int c = 1; c <= 18; c++) begin
            if (obs[c].bz) nbz++;
            if (obs[c].cr) ncr++;
        end
        n_tests++;
        if (nbz !== 18) begin n_fail++; $display("FAIL gauss_busy: got %0d expected 18", nbz); end
        n_tests++;
        if (ncr !== 0) begin n_fail++; $display("FAIL gauss_cmd_ready_while_busy: got %0d expected 0", ncr); end
        n_tests++;
        if (obs[19].er !== 1'b0) begin n_fail++; $display("FAIL gauss_err_ignored_cmd: got %b expected 0", obs[19].er); end
    endtask

    task automatic test_reserved();
        int nsr, nv;
        run_cmd(2'd3, 8'd5, 1'b0, 1'b0, -1, 20);
        n_tests++;
        if (done_cycle !== 2) begin n_fail++; $display("FAIL rsv_done_cycle: got %0d expected 2", done_cycle); end
        n_tests++;
        if (obs[2].er !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %b expected 1", obs[2].er); end
        nsr = 0; nv = 0;
        for (int c = 1; c <= last_c; c++) begin
            if (obs[c].sr) nsr++;
            if (obs[c].v) nv++;
        end
        n_tests++;
        if (nsr + nv !== 0) begin n_fail++; $display("FAIL rsv_no_src: got %0d ready/valid cycles expected 0", nsr + nv); end
        n_tests++;
        if ({obs[1].bz, obs[3].dn, obs[3].er} !== 3'b100) begin
            n_fail++; $display("FAIL rsv_pulse_shape: got %b expected 100", {obs[1].bz, obs[3].dn, obs[3].er});
        end
    endtask

    task automatic test_reset_mid_stream();
        obs_t e;
        int nd;
        run_cmd(2'd0, 8'd5, 1'b0, 1'b0, 3, 40);
        e = '0; e.cr = 1'b1;
        n_tests++;
        if (obs[4] !== e) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected %h", obs[4], e); end
        n_tests++;
        if (obs[5] !== e) begin n_fail++; $display("FAIL rstmid_after_release: got %h expected %h", obs[5], e); end
        nd = 0;
        for (int c = 4; c <= last_c; c++) if (obs[c].dn || obs[c].v) nd++;
        n_tests++;
        if (nd !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", nd); end
        run_cmd(2'd0, 8'd3, 1'b0, 1'b0, -1, 40);
        n_tests++;
        if (done_cycle !== 22) begin n_fail++; $display("FAIL rstmid_rerun_done: got %0d expected 22", done_cycle); end
    endtask

    task automatic test_max_len();
        obs_t e;
        int nv, ns;
        run_cmd(2'd0, 8'd255, 1'b0, 1'b0, -1, 300);
        nv = 0; ns = 0;
        for (int c = 1; c <= last_c; c++) begin
            if (obs[c].v) nv++;
            if (obs[c].st) ns++;
        end
        n_tests++;
        if (nv !== 256) begin n_fail++; $display("FAIL max_valid_count: got %0d expected 256", nv); end
        n_tests++;
        if (ns !== 1) begin n_fail++; $display("FAIL max_start_count: got %0d expected 1", ns); end
        n_tests++;
        if (done_cycle !== 274) begin n_fail++; $display("FAIL max_done_cycle: got %0d expected 274", done_cycle); end
        e = obs[257];
        e.v = 1'b1; e.st = 1'b0; e.op = 4'b1000; e.g = 2'b00; e.a = 4'd15; e.b = 4'd0;
        n_tests++;
        if (obs[257] !== e) begin n_fail++; $display("FAIL max_last_beat: got %h expected %h", obs[257], e); end
    endtask

    initial begin
        test_reset();
        test_mul_mat();
        test_eval_bubbles();
        test_gauss_len0();
        test_reserved();
        test_reset_mid_stream();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
